m24c16_seq_ctrl: RTL and testbench
==================================

// Module: m24c16_seq_ctrl
// PURPOSE
// Transaction sequencer for the I2C byte engine on the 24Cxx EEPROM bottomhalf.
// Turns one host command (sequential read / multi-byte write) into the engine's
// byte-step sequence: devsel, address, restart, data, stop, plus ACK polling.
// Writes are split at page boundaries. Sits between the host register file and the engine.
// PARAMETERS
// ADDR_W    11     EEPROM byte-address width; bits [ADDR_W-1:8] go into devsel bits 3:1
// PAGE_SIZE 16     write page size in bytes, power of 2
// POLL_MAX  1023   maximum devsel-write polls after a page write before error
// DEV_CODE  4'hA   devsel bits 7:4
// PORTS
// clock       in  1      engine step clock domain; all state on posedge
// reset       in  1      asynchronous, active-high
// cmd_valid   in  1      command request
// cmd_ready   out 1      high only in IDLE; command taken when valid&ready
// cmd_write   in  1      1 = write, 0 = read
// cmd_addr    in  ADDR_W start byte address
// cmd_len     in  8      transfer length minus 1 (1..256 bytes)
// wr_data     in  8      write byte
// wr_valid    in  1      write byte available
// wr_ready    out 1      byte consumed when wr_valid&wr_ready
// rd_data     out 8      read byte
// rd_valid    out 1      one-cycle strobe, no backpressure
// eng_req     out 1      step request; held until eng_done
// eng_byte    out 8      byte to shift (write steps)
// eng_read    out 1      step is a read
// eng_start   out 1      prefix (re)start condition
// eng_ack     out 1      write: check slave ACK; read: master drives ACK (1) / NACK (0)
// eng_stop    out 1      append stop condition
// eng_done    in  1      one-cycle step completion
// eng_nack    in  1      valid with eng_done: slave NACKed
// eng_rdata   in  8      valid with eng_done on read steps
// busy        out 1      not IDLE
// done        out 1      one-cycle strobe at command end (success or error)
// error       out 1      level; set with failing done, cleared on next accept
// bytes_done  out 9      data bytes transferred by the current command
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=1; every other output 0; counters 0. Reset mid-command
//   drops eng_req the same instant and the command is discarded; the engine is reset by the parent.
// - One engine step in flight max; eng_* fields stable while eng_req=1; eng_req falls the
//   cycle after eng_done; next step asserts no earlier than the following cycle.
// - devsel = {DEV_CODE, addr[ADDR_W-1:8], rw}; addr byte = addr[7:0].
// - FSM: IDLE -> DEVW (start, devsel w, ack) -> ADDR (addr byte, ack) -> write: WDATA / read: DEVR.
//   WDATA: wait wr_valid, wr_ready 1 cycle, step byte with ack; eng_stop=1 on the last byte of the
//   command or of the page (addr[log2 PAGE_SIZE-1:0]=all ones). Page end with bytes left -> POLL;
//   last byte -> POLL.
//   POLL: step start+devsel w+ack+stop. NACK -> repeat; ACK -> DEVW (more bytes) or FIN.
//   More than POLL_MAX NACKed polls -> ERR.
//   DEVR: start, devsel r, ack -> RDATA. RDATA: read step, eng_ack=1 except last byte
//   (eng_ack=0, eng_stop=1); rd_data/rd_valid the cycle after eng_done -> FIN after last.
//   FIN: done=1 one cycle -> IDLE. ERR: stop-only step, then error=1, done=1 -> IDLE.
// - NACK on any non-POLL write step -> ERR; remaining wr_data is not consumed.
// - Address counter increments per data byte, wraps modulo 2^ADDR_W (0x7FF -> 0x000).
// - bytes_done saturates at 256; cmd_valid while busy is ignored.
// STRUCTURE
// - Shared package m24c16_seq_pkg: state encoding, DEV_CODE, RW_READ/RW_WRITE constants.
// - No sub-module; the byte engine is instantiated beside this block by the parent.
// TESTING
// 1 read addr 0x7FF len=1 (2 bytes) -> steps A0|0x0E? no: devsel 0xAE, addr 0xFF, 0xAF restart, read ack=1, read ack=0+stop; 2 rd_valid; done, error=0.
// 2 write addr 0x00E len=3 -> bytes @0x00E,0x00F stop; poll; devsel 0xA0 addr 0x10; 2 bytes stop; poll; done.
// 3 write 1 byte, poll NACKed 3x then ACK -> exactly 4 poll steps, done, error=0, bytes_done=1.
// 4 NACK on address step -> one stop-only step, error=1, done pulse, wr_ready never high.
// 5 POLL_MAX=4, all polls NACK -> 5 polls, then stop step, error=1.
// 6 reset pulse mid-WDATA -> eng_req=0 immediately; after release cmd_ready=1, bytes_done=0.

Source files
------------

// File: rtl/m24c16_seq_pkg.sv
// Shared definitions for the 24Cxx transaction sequencer: state encoding and
// device-select constants.
package m24c16_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEVW,
        S_ADDR,
        S_WDATA,
        S_POLL,
        S_DEVR,
        S_RDATA,
        S_FIN,
        S_ERR
    } state_t;

    localparam logic [3:0] DEV_CODE_DEFAULT = 4'hA;
    localparam logic       RW_WRITE         = 1'b0;
    localparam logic       RW_READ          = 1'b1;

endpackage

// File: rtl/m24c16_seq_ctrl.sv
// Sequencer turning one host read/write command into byte-engine steps, with
// page splitting and ACK polling after every page write.
module m24c16_seq_ctrl
    import m24c16_seq_pkg::*;
#(
    parameter int         ADDR_W    = 11,
    parameter int         PAGE_SIZE = 16,
    parameter int         POLL_MAX  = 1023,
    parameter logic [3:0] DEV_CODE  = DEV_CODE_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              eng_req,
    output logic [7:0]        eng_byte,
    output logic              eng_read,
    output logic              eng_start,
    output logic              eng_ack,
    output logic              eng_stop,
    input  logic              eng_done,
    input  logic              eng_nack,
    input  logic [7:0]        eng_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [8:0]        bytes_done
);

    localparam int PAGE_W = $clog2(PAGE_SIZE);
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    state_t            state, next;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        left;
    logic [POLL_W-1:0] poll_cnt;
    logic              is_write;

    logic       issue, step_end, last, page_end;
    logic [2:0] blk;
    logic [7:0] devsel_w, devsel_r, st_byte;
    logic       st_read, st_start, st_ack, st_stop;

    assign blk      = 3'(addr >> 8);
    assign devsel_w = {DEV_CODE, blk, RW_WRITE};
    assign devsel_r = {DEV_CODE, blk, RW_READ};
    assign last     = (left == 9'd1);
    assign page_end = &addr[PAGE_W-1:0];
    assign step_end = eng_req && eng_done;
    assign busy     = (state != S_IDLE);

    // Each step state launches its step whenever no step is in flight; the
    // cycle eng_req drops after completion provides the mandatory gap.
    always_comb begin
        next      = state;
        issue     = 1'b0;
        st_byte   = 8'h00;
        st_read   = 1'b0;
        st_start  = 1'b0;
        st_ack    = 1'b0;
        st_stop   = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next = S_DEVW;
            end
            S_DEVW: begin
                issue    = !eng_req;
                st_byte  = devsel_w;
                st_start = 1'b1;
                st_ack   = 1'b1;
                if (step_end) next = eng_nack ? S_ERR : S_ADDR;
            end
            S_ADDR: begin
                issue   = !eng_req;
                st_byte = addr[7:0];
                st_ack  = 1'b1;
                if (step_end) next = eng_nack ? S_ERR : (is_write ? S_WDATA : S_DEVR);
            end
            S_WDATA: begin
                wr_ready = !eng_req && wr_valid;
                issue    = wr_ready;
                st_byte  = wr_data;
                st_ack   = 1'b1;
                st_stop  = last || page_end;
                if (step_end) next = eng_nack ? S_ERR : (eng_stop ? S_POLL : S_WDATA);
            end
            S_POLL: begin
                issue    = !eng_req;
                st_byte  = devsel_w;
                st_start = 1'b1;
                st_ack   = 1'b1;
                st_stop  = 1'b1;
                if (step_end) begin
                    if (eng_nack) next = (poll_cnt == POLL_W'(POLL_MAX)) ? S_ERR : S_POLL;
                    else          next = (left != 9'd0) ? S_DEVW : S_FIN;
                end
            end
            S_DEVR: begin
                issue    = !eng_req;
                st_byte  = devsel_r;
                st_start = 1'b1;
                st_ack   = 1'b1;
                if (step_end) next = eng_nack ? S_ERR : S_RDATA;
            end
            S_RDATA: begin
                issue   = !eng_req;
                st_read = 1'b1;
                st_ack  = !last;
                st_stop = last;
                if (step_end && last) next = S_FIN;
            end
            S_FIN: begin
                done = 1'b1;
                next = S_IDLE;
            end
            S_ERR: begin
                issue   = !eng_req;
                st_stop = 1'b1;
                if (step_end) next = S_FIN;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            left       <= '0;
            poll_cnt   <= '0;
            is_write   <= 1'b0;
            eng_req    <= 1'b0;
            eng_byte   <= 8'h00;
            eng_read   <= 1'b0;
            eng_start  <= 1'b0;
            eng_ack    <= 1'b0;
            eng_stop   <= 1'b0;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            error      <= 1'b0;
            bytes_done <= '0;
        end else begin
            state    <= next;
            rd_valid <= 1'b0;
            if (issue) begin
                eng_req   <= 1'b1;
                eng_byte  <= st_byte;
                eng_read  <= st_read;
                eng_start <= st_start;
                eng_ack   <= st_ack;
                eng_stop  <= st_stop;
            end else if (step_end) begin
                eng_req <= 1'b0;
            end
            if (state == S_IDLE && cmd_valid) begin
                is_write   <= cmd_write;
                addr       <= cmd_addr;
                left       <= 9'(cmd_len) + 9'd1;
                poll_cnt   <= '0;
                error      <= 1'b0;
                bytes_done <= '0;
            end
            if (step_end && ((state == S_WDATA && !eng_nack) || state == S_RDATA)) begin
                addr <= addr + 1'b1;
                left <= left - 9'd1;
                if (bytes_done != 9'd256) bytes_done <= bytes_done + 9'd1;
            end
            if (step_end && state == S_RDATA) begin
                rd_data  <= eng_rdata;
                rd_valid <= 1'b1;
            end
            if (step_end && state == S_POLL)
                poll_cnt <= eng_nack ? poll_cnt + 1'b1 : '0;
            if (step_end && state == S_ERR)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m24c16_seq_ctrl.sv
// Scoreboard bench for the 24Cxx sequencer: directed commands push expected
// engine steps, read bytes and completions; a monitor pops and compares.
module tb_m24c16_seq_ctrl;

    localparam logic [3:0] F_DEV  = 4'b0110; // {read, start, ack, stop}
    localparam logic [3:0] F_WB   = 4'b0010;
    localparam logic [3:0] F_WBS  = 4'b0011;
    localparam logic [3:0] F_POLL = 4'b0111;
    localparam logic [3:0] F_RD   = 4'b1010;
    localparam logic [3:0] F_RDL  = 4'b1001;
    localparam logic [3:0] F_STOP = 4'b0001;

    typedef struct {
        int         kind;   // 0 step, 1 read byte, 2 done
        logic [7:0] b;
        logic       bc;
        logic [3:0] f;
        logic [9:0] v;
    } ev_t;

    logic        clock, reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr;
    logic [7:0]  cmd_len, wr_data, rd_data, eng_byte, eng_rdata;
    logic        wr_valid, wr_ready, rd_valid;
    logic        eng_req, eng_read, eng_start, eng_ack, eng_stop, eng_done, eng_nack;
    logic        busy, done, error;
    logic [8:0]  bytes_done;

    ev_t        exp_q[$];
    logic [8:0] resp_q[$];
    logic [7:0] wr_q[$];
    int checks = 0, errors = 0, done_seen = 0, wr_ready_cnt = 0;

    m24c16_seq_ctrl #(.ADDR_W(11), .PAGE_SIZE(16), .POLL_MAX(4), .DEV_CODE(4'hA)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .eng_req(eng_req), .eng_byte(eng_byte), .eng_read(eng_read),
        .eng_start(eng_start), .eng_ack(eng_ack), .eng_stop(eng_stop),
        .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata),
        .busy(busy), .done(done), .error(error), .bytes_done(bytes_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_ev(input int k, output bit ok, output ev_t e);
        ok = 1'b0;
        e  = '{kind: -1, b: 8'h00, bc: 1'b0, f: 4'h0, v: 10'h000};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event got kind=%0d expected=none at %0t", k, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            ok = (e.kind == k);
        end
    endtask

    task automatic exp_step(input logic [7:0] b, input logic bc, input logic [3:0] f,
                            input logic nk, input logic [7:0] rdat);
        exp_q.push_back('{kind: 0, b: b, bc: bc, f: f, v: 10'h000});
        resp_q.push_back({nk, rdat});
    endtask

    task automatic exp_rd(input logic [7:0] d);
        exp_q.push_back('{kind: 1, b: 8'h00, bc: 1'b0, f: 4'h0, v: {2'b00, d}});
    endtask

    task automatic exp_done(input logic err, input logic [8:0] cnt);
        exp_q.push_back('{kind: 2, b: 8'h00, bc: 1'b0, f: 4'h0, v: {err, cnt}});
    endtask

    // Engine model: answers each step after two idle cycles, using scripted responses.
    initial begin
        int         wt;
        logic       active;
        logic [8:0] r;
        eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
        active = 1'b0; wt = 0;
        forever begin
            @(posedge clock); #1;
            eng_done = 1'b0;
            eng_nack = 1'b0;
            if (reset) active = 1'b0;
            else if (!active) begin
                if (eng_req) begin active = 1'b1; wt = 1; end
            end else if (wt > 0) wt--;
            else begin
                r = (resp_q.size() > 0) ? resp_q.pop_front() : 9'h000;
                eng_done  = 1'b1;
                eng_nack  = r[8];
                eng_rdata = r[7:0];
                active    = 1'b0;
            end
        end
    end

    // Write-byte source
    initial begin
        logic hs;
        wr_valid = 1'b0; wr_data = 8'h00;
        forever begin
            @(negedge clock);
            hs = wr_valid && wr_ready;
            @(posedge clock); #1;
            if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() > 0);
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
        end
    end

    // Monitor
    initial begin
        ev_t         e;
        bit          ok;
        logic        prev;
        logic [11:0] held;
        prev = 1'b0; held = 12'h000;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (eng_req && !prev) begin
                    held = {eng_read, eng_start, eng_ack, eng_stop, eng_byte};
                    pop_ev(0, ok, e);
                    if (ok) begin
                        chk("step_flags", 32'({eng_read, eng_start, eng_ack, eng_stop}), 32'(e.f));
                        if (e.bc) chk("step_byte", 32'(eng_byte), 32'(e.b));
                    end
                end else if (eng_req) begin
                    chk("step_stable", 32'({eng_read, eng_start, eng_ack, eng_stop, eng_byte}), 32'(held));
                end
                if (rd_valid) begin
                    pop_ev(1, ok, e);
                    if (ok) chk("rd_data", 32'(rd_data), 32'(e.v));
                end
                if (done) begin
                    done_seen++;
                    pop_ev(2, ok, e);
                    if (ok) chk("done_error_count", 32'({error, bytes_done}), 32'(e.v));
                end
                if (wr_ready) wr_ready_cnt++;
            end
            prev = eng_req;
        end
    end

    task automatic run_cmd(input logic w, input logic [10:0] a, input logic [7:0] l, input string name);
        int start_done = done_seen;
        int n = 0;
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        while (done_seen == start_done && n < 3000) begin
            @(posedge clock);
            n++;
        end
        chk({name, "_completed"}, 32'(done_seen != start_done), 32'd1);
        repeat (3) @(posedge clock);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        resp_q.delete();
    endtask

    initial begin
        int n, wr0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        #1 reset = 1'b1;
        #20 reset = 1'b0;
        @(negedge clock);
        chk("reset_outputs",
            32'({cmd_ready, eng_req, busy, done, error, wr_ready, rd_valid, bytes_done}),
            32'({1'b1, 6'b000000, 9'd0}));

        // 1: read two bytes across the top of the array
        exp_step(8'hAE, 1, F_DEV, 0, 0);
        exp_step(8'hFF, 1, F_WB, 0, 0);
        exp_step(8'hAF, 1, F_DEV, 0, 0);
        exp_step(8'h00, 0, F_RD, 0, 8'h5A);  exp_rd(8'h5A);
        exp_step(8'h00, 0, F_RDL, 0, 8'hC3); exp_rd(8'hC3);
        exp_done(1'b0, 9'd2);
        run_cmd(1'b0, 11'h7FF, 8'd1, "t1");

        // 2: four-byte write split at the 0x00F page end
        wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33); wr_q.push_back(8'h44);
        exp_step(8'hA0, 1, F_DEV, 0, 0);
        exp_step(8'h0E, 1, F_WB, 0, 0);
        exp_step(8'h11, 1, F_WB, 0, 0);
        exp_step(8'h22, 1, F_WBS, 0, 0);
        exp_step(8'hA0, 1, F_POLL, 0, 0);
        exp_step(8'hA0, 1, F_DEV, 0, 0);
        exp_step(8'h10, 1, F_WB, 0, 0);
        exp_step(8'h33, 1, F_WB, 0, 0);
        exp_step(8'h44, 1, F_WBS, 0, 0);
        exp_step(8'hA0, 1, F_POLL, 0, 0);
        exp_done(1'b0, 9'd4);
        run_cmd(1'b1, 11'h00E, 8'd3, "t2");

        // 3: single byte, three busy polls then ACK
        wr_q.push_back(8'h5C);
        exp_step(8'hA2, 1, F_DEV, 0, 0);
        exp_step(8'h23, 1, F_WB, 0, 0);
        exp_step(8'h5C, 1, F_WBS, 0, 0);
        for (int i = 0; i < 3; i++) exp_step(8'hA2, 1, F_POLL, 1, 0);
        exp_step(8'hA2, 1, F_POLL, 0, 0);
        exp_done(1'b0, 9'd1);
        run_cmd(1'b1, 11'h123, 8'd0, "t3");

        // 4: address byte NACKed, data never consumed
        wr_q.push_back(8'h77);
        wr0 = wr_ready_cnt;
        exp_step(8'hA0, 1, F_DEV, 0, 0);
        exp_step(8'h00, 1, F_WB, 1, 0);
        exp_step(8'h00, 0, F_STOP, 0, 0);
        exp_done(1'b1, 9'd0);
        run_cmd(1'b1, 11'h000, 8'd0, "t4");
        chk("t4_wr_ready_never", 32'(wr_ready_cnt - wr0), 32'd0);
        wr_q.delete();
        repeat (2) @(posedge clock);

        // 5: polling exhausted after POLL_MAX+1 NACKs
        wr_q.push_back(8'h99);
        exp_step(8'hA0, 1, F_DEV, 0, 0);
        exp_step(8'h00, 1, F_WB, 0, 0);
        exp_step(8'h99, 1, F_WBS, 0, 0);
        for (int i = 0; i < 5; i++) exp_step(8'hA0, 1, F_POLL, 1, 0);
        exp_step(8'h00, 0, F_STOP, 0, 0);
        exp_done(1'b1, 9'd1);
        run_cmd(1'b1, 11'h000, 8'd0, "t5");

        // 6: reset while a data step is in flight
        wr_q.push_back(8'h3C);
        exp_step(8'hA0, 1, F_DEV, 0, 0);
        exp_step(8'h40, 1, F_WB, 0, 0);
        exp_step(8'h3C, 1, F_WB, 0, 0);
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h040; cmd_len = 8'd3;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(eng_req && !eng_start && eng_byte == 8'h3C) && n < 500);
        chk("t6_reached_data_step", 32'(eng_req && !eng_start && eng_byte == 8'h3C), 32'd1);
        chk("t6_error_cleared_on_accept", 32'(error), 32'd0);
        #2 reset = 1'b1;
        #1 chk("t6_req_drops_on_reset", 32'(eng_req), 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        resp_q.delete();
        @(negedge clock);
        chk("t6_after_reset", 32'({cmd_ready, busy, error, bytes_done}), 32'({1'b1, 1'b0, 1'b0, 9'd0}));
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
